// File: rtl/core_axi_rd_arbiter_if.sv
// AXI4-Lite read-channel bundle (AR + R) shared by the arbiter's two masters and its memory port.
interface core_axi_rd_arbiter_if #(
  parameter int unsigned AXI_AWIDTH = 4,
  parameter int unsigned AXI_DWIDTH = 32
);
  logic [AXI_AWIDTH-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [AXI_DWIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport master (output ARADDR, ARVALID, RREADY, input ARREADY, RDATA, RRESP, RVALID);
  modport slave  (input ARADDR, ARVALID, RREADY, output ARREADY, RDATA, RRESP, RVALID);
endinterface

// File: rtl/core_axi_rd_arbiter.sv
// Two-master AXI4-Lite read arbiter: round-robin AR grant, grant held until the R beat completes,
// with a per-transaction response timeout that forces SLVERR back to the granted master.
module core_axi_rd_arbiter #(
  parameter int unsigned AXI_AWIDTH     = 4,
  parameter int unsigned AXI_DWIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  CLK,
  input  logic                  NRST,
  core_axi_rd_arbiter_if.slave  M0,
  core_axi_rd_arbiter_if.slave  M1,
  core_axi_rd_arbiter_if.master S,
  output logic                  GNT_ID,
  output logic                  BUSY
);
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_e;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;

  logic                  g_arvalid;
  logic                  g_rready;
  logic [AXI_AWIDTH-1:0] g_araddr;
  logic                  timed_out;

  logic                  ar_ready;
  logic                  r_valid;
  logic [AXI_DWIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  s_arvalid;
  logic [AXI_AWIDTH-1:0] s_araddr;
  logic                  s_rready;

  assign g_arvalid = gnt_q ? M1.ARVALID : M0.ARVALID;
  assign g_araddr  = gnt_q ? M1.ARADDR  : M0.ARADDR;
  assign g_rready  = gnt_q ? M1.RREADY  : M0.RREADY;
  assign timed_out = (cnt_q == TIMEOUT_LIM);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    r_data    = '0;
    r_resp    = '0;
    s_arvalid = 1'b0;
    s_araddr  = '0;
    s_rready  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (M0.ARVALID && M1.ARVALID) begin
          gnt_d   = ~last_q;
          state_d = ST_ADDR;
        end else if (M0.ARVALID) begin
          gnt_d   = 1'b0;
          state_d = ST_ADDR;
        end else if (M1.ARVALID) begin
          gnt_d   = 1'b1;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        s_araddr  = g_araddr;
        s_arvalid = g_arvalid;
        ar_ready  = S.ARREADY;
        if (g_arvalid && S.ARREADY) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end else if (!g_arvalid) begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        // Once timed out the memory is disconnected; a late S_RVALID is never acknowledged.
        if (timed_out) begin
          r_valid = 1'b1;
          r_resp  = 2'b10;
          if (g_rready) begin
            last_d  = gnt_q;
            state_d = ST_IDLE;
          end
        end else begin
          r_valid  = S.RVALID;
          r_data   = S.RDATA;
          r_resp   = S.RRESP;
          s_rready = g_rready;
          if (S.RVALID && g_rready) begin
            last_d  = gnt_q;
            state_d = ST_IDLE;
          end else if (!S.RVALID) begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign M0.ARREADY = ar_ready & ~gnt_q;
  assign M1.ARREADY = ar_ready &  gnt_q;
  assign M0.RVALID  = r_valid  & ~gnt_q;
  assign M1.RVALID  = r_valid  &  gnt_q;
  assign M0.RDATA   = gnt_q ? '0 : r_data;
  assign M1.RDATA   = gnt_q ? r_data : '0;
  assign M0.RRESP   = gnt_q ? 2'b00 : r_resp;
  assign M1.RRESP   = gnt_q ? r_resp : 2'b00;

  assign S.ARADDR  = s_araddr;
  assign S.ARVALID = s_arvalid;
  assign S.RREADY  = s_rready;

  assign GNT_ID = gnt_q;
  assign BUSY   = (state_q != ST_IDLE);
endmodule

// File: tb/tb_core_axi_rd_arbiter.sv
// Bench for core_axi_rd_arbiter: bus agents for both masters and the memory, with a request-level
// model predicting grant order and per-master read results.
module tb_core_axi_rd_arbiter;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic nrst;
  logic gnt_id, busy;
  always #5 clk = ~clk;

  core_axi_rd_arbiter_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) m0_if ();
  core_axi_rd_arbiter_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) m1_if ();
  core_axi_rd_arbiter_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) s_if ();

  core_axi_rd_arbiter #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(clk), .NRST(nrst), .M0(m0_if), .M1(m1_if), .S(s_if), .GNT_ID(gnt_id), .BUSY(busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mem_data [16];
  logic [1:0]  mem_resp [16];
  logic [3:0]  rq0[$], rq1[$];
  logic [33:0] exp0[$], exp1[$], got0[$], got1[$];
  int          exp_order[$], ar_order[$];
  int          mdl_last;

  int ar_min, ar_max, r_min, r_max;
  bit silent, rready_all;

  bit          mem_busy;
  logic [3:0]  mem_addr;
  int          r_cnt, r_lat_cur, ar_cnt, ar_lat_cur;
  bit          f_ar0, f_ar1, f_r0, f_r1, f_sar, f_sr;
  logic [33:0] cap0, cap1;
  logic [3:0]  cap_saddr;
  int          cyc, ar_iter, rv_first;
  bit          rv_seen, m1_rv_seen;
  int          viol;
  string       viol_why;

  function automatic void note(input string why);
    viol++;
    if (viol == 1) viol_why = why;
  endfunction

  // Agents: act at negedge on handshakes flagged for the previous posedge, drive, then flag again.
  initial begin
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!nrst) begin
        mem_busy = 1'b0; ar_cnt = 0; r_cnt = 0;
        f_ar0 = 0; f_ar1 = 0; f_r0 = 0; f_r1 = 0; f_sar = 0; f_sr = 0;
        m0_if.ARVALID = 1'b0; m0_if.RREADY = 1'b0; m0_if.ARADDR = '0;
        m1_if.ARVALID = 1'b0; m1_if.RREADY = 1'b0; m1_if.ARADDR = '0;
        s_if.ARREADY = 1'b0; s_if.RVALID = 1'b0; s_if.RDATA = '0; s_if.RRESP = '0;
      end else begin
        if (f_ar0) begin void'(rq0.pop_front()); ar_order.push_back(0); end
        if (f_ar1) begin void'(rq1.pop_front()); ar_order.push_back(1); end
        if (f_r0) got0.push_back(cap0);
        if (f_r1) got1.push_back(cap1);
        if (f_sar) begin
          if (mem_busy) note("AR accepted while memory busy");
          mem_busy = 1'b1; mem_addr = cap_saddr; r_cnt = 0;
          r_lat_cur = int'($urandom_range(r_max, r_min));
          ar_cnt = 0;
          ar_lat_cur = int'($urandom_range(ar_max, ar_min));
        end
        if (f_r0 || f_r1) begin mem_busy = 1'b0; s_if.RVALID = 1'b0; end

        m0_if.ARVALID = (rq0.size() != 0);
        m0_if.ARADDR  = (rq0.size() != 0) ? rq0[0] : 4'h0;
        m0_if.RREADY  = rready_all ? 1'b1 : ($urandom_range(0, 2) != 0);
        m1_if.ARVALID = (rq1.size() != 0);
        m1_if.ARADDR  = (rq1.size() != 0) ? rq1[0] : 4'h0;
        m1_if.RREADY  = rready_all ? 1'b1 : ($urandom_range(0, 2) != 0);
        s_if.ARREADY  = !mem_busy && (ar_cnt >= ar_lat_cur);
        if (mem_busy && !silent && !s_if.RVALID) begin
          if (r_cnt >= r_lat_cur) begin
            s_if.RVALID = 1'b1;
            s_if.RDATA  = mem_data[mem_addr];
            s_if.RRESP  = mem_resp[mem_addr];
          end else begin
            r_cnt++;
            s_if.RDATA = $urandom;
          end
        end else if (!s_if.RVALID) begin
          s_if.RDATA = $urandom;
        end

        #1;
        f_ar0 = m0_if.ARVALID && m0_if.ARREADY;
        f_ar1 = m1_if.ARVALID && m1_if.ARREADY;
        f_r0  = m0_if.RVALID && m0_if.RREADY;
        f_r1  = m1_if.RVALID && m1_if.RREADY;
        f_sar = s_if.ARVALID && s_if.ARREADY;
        f_sr  = s_if.RVALID && s_if.RREADY;
        cap0  = {m0_if.RRESP, m0_if.RDATA};
        cap1  = {m1_if.RRESP, m1_if.RDATA};
        cap_saddr = s_if.ARADDR;
        if ((f_ar0 || f_ar1) != f_sar) note("master/memory AR handshakes disagree");
        if (f_ar0 && f_ar1) note("both masters accepted");
        if (f_sar && f_ar0 && s_if.ARADDR !== m0_if.ARADDR) note("S_ARADDR != M0_ARADDR");
        if (f_sar && f_ar1 && s_if.ARADDR !== m1_if.ARADDR) note("S_ARADDR != M1_ARADDR");
        if (f_ar0 && gnt_id !== 1'b0) note("M0 accepted without grant");
        if (f_ar1 && gnt_id !== 1'b1) note("M1 accepted without grant");
        if (m0_if.RVALID && m1_if.RVALID) note("both RVALID");
        if (m0_if.RVALID && gnt_id !== 1'b0) note("M0_RVALID without grant");
        if (m1_if.RVALID && gnt_id !== 1'b1) note("M1_RVALID without grant");
        if (gnt_id === 1'b1 && {m0_if.RRESP, m0_if.RDATA} !== 34'h0) note("M0 R bus not zero");
        if (gnt_id === 1'b0 && {m1_if.RRESP, m1_if.RDATA} !== 34'h0) note("M1 R bus not zero");
        if (!s_if.ARVALID && s_if.ARADDR !== 4'h0) note("S_ARADDR not zero while idle");
        if (f_sr && !(f_r0 || f_r1)) note("memory R accepted but not delivered");
        if (silent && s_if.RREADY && (m0_if.RVALID || m1_if.RVALID)) note("S_RREADY during timeout");
        if (m1_if.RVALID) m1_rv_seen = 1'b1;
        if (f_sar) begin ar_iter = cyc; rv_seen = 1'b0; end
        if ((m0_if.RVALID || m1_if.RVALID) && !rv_seen) begin rv_first = cyc; rv_seen = 1'b1; end
        if (s_if.ARVALID && !s_if.ARREADY) ar_cnt++;
      end
    end
  end

  // Reference model: queue a read and predict its result from the memory contents.
  function automatic void enq(input int m, input logic [3:0] a);
    if (m == 0) begin rq0.push_back(a); exp0.push_back({mem_resp[a], mem_data[a]}); end
    else        begin rq1.push_back(a); exp1.push_back({mem_resp[a], mem_data[a]}); end
  endfunction

  // Round-robin over masters that keep requesting: the one not served last wins a tie.
  function automatic void model_order(input int n0, input int n1);
    int g;
    while (n0 > 0 || n1 > 0) begin
      if (n0 > 0 && n1 > 0) g = (mdl_last == 0) ? 1 : 0;
      else g = (n0 > 0) ? 0 : 1;
      exp_order.push_back(g);
      mdl_last = g;
      if (g == 0) n0--; else n1--;
    end
  endfunction

  task automatic clear_logs();
    got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
    ar_order.delete(); exp_order.delete();
    viol = 0; viol_why = ""; m1_rv_seen = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    nrst = 1'b0;
    rq0.delete(); rq1.delete();
    clear_logs();
    @(negedge clk); #2;
    nrst = 1'b1;
    mdl_last = 1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #2;
      if (got0.size() == exp0.size() && got1.size() == exp1.size() &&
          rq0.size() == 0 && rq1.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #2 nrst = 1'b1;
    mdl_last = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #2;
      n_chk++;
      if ({busy, s_if.ARVALID, s_if.RREADY, m0_if.ARREADY, m1_if.ARREADY, m0_if.RVALID, m1_if.RVALID} !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: outputs %b, expected 0000000", i,
                 {busy, s_if.ARVALID, s_if.RREADY, m0_if.ARREADY, m1_if.ARREADY, m0_if.RVALID, m1_if.RVALID});
      end
    end
    n_chk++;
    if (gnt_id !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: GNT_ID %b, expected 0", gnt_id); end
  endtask

  task automatic test_m0_single();
    bit ok;
    clear_logs();
    mem_data[4] = 32'h0000_0013; mem_resp[4] = 2'b00;
    ar_min = 2; ar_max = 2; ar_lat_cur = 2; r_min = 1; r_max = 1; rready_all = 1'b1;
    enq(0, 4'h4);
    model_order(1, 0);
    wait_done(200, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL m0_single_done: got %0d beats, expected 1", got0.size()); end
    n_chk++;
    if (ok && got0[0] !== {2'b00, 32'h0000_0013}) begin
      n_fail++; $display("FAIL m0_single_data: got %h, expected 000000013", got0[0]);
    end
    n_chk++;
    if (m1_rv_seen) begin n_fail++; $display("FAIL m0_single_m1_rvalid: M1_RVALID seen 1, expected never"); end
    n_chk++;
    if (gnt_id !== 1'b0) begin n_fail++; $display("FAIL m0_single_gnt: GNT_ID %b, expected 0", gnt_id); end
    n_chk++;
    if (viol != 0) begin n_fail++; $display("FAIL m0_single_protocol: %0d violations (%s), expected 0", viol, viol_why); end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    ar_min = 0; ar_max = 2; r_min = 0; r_max = 3; rready_all = 1'b0;
    for (int i = 0; i < 2; i++) begin
      enq(0, 4'($urandom_range(0, 15)));
      enq(1, 4'($urandom_range(0, 15)));
    end
    model_order(2, 2);
    wait_done(400, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL rr_done: %0d transactions, expected 4", ar_order.size()); end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (i >= ar_order.size() || ar_order[i] != exp_order[i]) begin
        n_fail++; $display("FAIL rr_order[%0d]: got M%0d, expected M%0d", i,
                           (i < ar_order.size()) ? ar_order[i] : -1, exp_order[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (ok && (got0[i] !== exp0[i] || got1[i] !== exp1[i])) begin
        n_fail++; $display("FAIL rr_data[%0d]: got %h/%h, expected %h/%h", i, got0[i], got1[i], exp0[i], exp1[i]);
      end
    end
    n_chk++;
    if (viol != 0) begin n_fail++; $display("FAIL rr_protocol: %0d violations (%s), expected 0", viol, viol_why); end
  endtask

  task automatic test_busy_wait();
    bit ok, early;
    int i;
    clear_logs();
    ar_min = 0; ar_max = 0; ar_lat_cur = 0; r_min = 6; r_max = 6; rready_all = 1'b1;
    enq(1, 4'h9);
    model_order(0, 1);
    for (i = 0; i < 50 && ar_order.size() == 0; i++) begin @(negedge clk); #2; end
    n_chk++;
    if (ar_order.size() != 1) begin n_fail++; $display("FAIL busy_m1_accept: %0d ARs, expected 1", ar_order.size()); end
    enq(0, 4'h3);
    model_order(1, 0);
    early = 1'b0;
    for (i = 0; i < 50 && got1.size() == 0; i++) begin
      @(negedge clk); #2;
      if (got1.size() == 0 && (m0_if.ARREADY !== 1'b0 || gnt_id !== 1'b1)) early = 1'b1;
    end
    n_chk++;
    if (early) begin n_fail++; $display("FAIL busy_m0_blocked: M0_ARREADY/grant changed early, expected held on M1"); end
    wait_done(200, ok);
    n_chk++;
    if (!ok || ar_order.size() != 2 || ar_order[1] != 0) begin
      n_fail++; $display("FAIL busy_m0_after: %0d ARs, expected M1 then M0", ar_order.size());
    end
    n_chk++;
    if (ok && (got0[0] !== exp0[0] || got1[0] !== exp1[0])) begin
      n_fail++; $display("FAIL busy_data: got %h/%h, expected %h/%h", got0[0], got1[0], exp0[0], exp1[0]);
    end
    n_chk++;
    if (viol != 0) begin n_fail++; $display("FAIL busy_protocol: %0d violations (%s), expected 0", viol, viol_why); end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_logs();
    silent = 1'b1; rready_all = 1'b0; ar_min = 0; ar_max = 1; r_min = 0; r_max = 2;
    rq0.push_back(4'h5);
    exp0.push_back({2'b10, 32'h0});
    model_order(1, 0);
    wait_done(200, ok);
    n_chk++;
    if (!ok || got0[0] !== {2'b10, 32'h0}) begin
      n_fail++; $display("FAIL timeout_resp: got %h, expected 200000000", ok ? got0[0] : 34'h0);
    end
    n_chk++;
    if (rv_first - ar_iter != int'(TO) + 1) begin
      n_fail++; $display("FAIL timeout_latency: RVALID %0d cycles after AR, expected %0d", rv_first - ar_iter, TO + 1);
    end
    n_chk++;
    if (viol != 0) begin n_fail++; $display("FAIL timeout_protocol: %0d violations (%s), expected 0", viol, viol_why); end
    silent = 1'b0;
    clear_logs();
    mem_data[7] = 32'hCAFE_0007; mem_resp[7] = 2'b01;
    enq(0, 4'h7);
    model_order(1, 0);
    wait_done(200, ok);
    n_chk++;
    if (!ok || got0[0] !== {2'b01, 32'hCAFE_0007}) begin
      n_fail++; $display("FAIL timeout_recover: got %h, expected 1cafe0007", ok ? got0[0] : 34'h0);
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    int i;
    clear_logs();
    silent = 1'b1; rready_all = 1'b1; ar_min = 0; ar_max = 0; ar_lat_cur = 0;
    rq1.push_back(4'h2);
    for (i = 0; i < 50 && ar_order.size() == 0; i++) begin @(negedge clk); #2; end
    n_chk++;
    if (ar_order.size() != 1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_enter: %0d ARs busy=%b, expected 1 and 1", ar_order.size(), busy);
    end
    repeat (2) @(negedge clk);
    do_reset();
    n_chk++;
    if (busy !== 1'b0 || gnt_id !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_state: BUSY=%b GNT_ID=%b, expected 0 0", busy, gnt_id);
    end
    silent = 1'b0;
    bad = 1'b0;
    for (i = 0; i < 12; i++) begin
      @(negedge clk); #2;
      if (m0_if.RVALID !== 1'b0 || m1_if.RVALID !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    n_chk++;
    if (bad || got0.size() != 0 || got1.size() != 0) begin
      n_fail++; $display("FAIL rstmid_no_resp: %0d/%0d beats delivered, expected none", got0.size(), got1.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    int n0, n1;
    for (int r = 0; r < 6; r++) begin
      clear_logs();
      for (int a = 0; a < 16; a++) begin mem_data[a] = $urandom; mem_resp[a] = 2'($urandom_range(0, 3)); end
      ar_min = 0; ar_max = int'($urandom_range(0, 3)); r_min = 0; r_max = int'($urandom_range(0, 4));
      rready_all = 1'b0;
      n0 = int'($urandom_range(0, 5)); n1 = int'($urandom_range(0, 5));
      if (n0 + n1 == 0) n0 = 1;
      for (int k = 0; k < n0; k++) enq(0, 4'($urandom_range(0, 15)));
      for (int k = 0; k < n1; k++) enq(1, 4'($urandom_range(0, 15)));
      model_order(n0, n1);
      wait_done(2000, ok);
      n_chk++;
      if (!ok) begin n_fail++; $display("FAIL rand%0d_done: %0d/%0d beats, expected %0d/%0d", r, got0.size(), got1.size(), n0, n1); end
      for (int i = 0; i < exp_order.size(); i++) begin
        n_chk++;
        if (i >= ar_order.size() || ar_order[i] != exp_order[i]) begin
          n_fail++; $display("FAIL rand%0d_order[%0d]: got M%0d, expected M%0d", r, i,
                             (i < ar_order.size()) ? ar_order[i] : -1, exp_order[i]);
        end
      end
      for (int i = 0; i < exp0.size(); i++) begin
        n_chk++;
        if (i >= got0.size() || got0[i] !== exp0[i]) begin
          n_fail++; $display("FAIL rand%0d_m0[%0d]: got %h, expected %h", r, i, (i < got0.size()) ? got0[i] : 34'h0, exp0[i]);
        end
      end
      for (int i = 0; i < exp1.size(); i++) begin
        n_chk++;
        if (i >= got1.size() || got1[i] !== exp1[i]) begin
          n_fail++; $display("FAIL rand%0d_m1[%0d]: got %h, expected %h", r, i, (i < got1.size()) ? got1[i] : 34'h0, exp1[i]);
        end
      end
      @(negedge clk); #2;
      n_chk++;
      if (viol != 0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_protocol: %0d violations (%s) busy=%b, expected 0 and 0", r, viol, viol_why, busy);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0;
    m0_if.ARVALID = 1'b0; m0_if.ARADDR = '0; m0_if.RREADY = 1'b0;
    m1_if.ARVALID = 1'b0; m1_if.ARADDR = '0; m1_if.RREADY = 1'b0;
    s_if.ARREADY = 1'b0; s_if.RVALID = 1'b0; s_if.RDATA = '0; s_if.RRESP = '0;
    silent = 1'b0; rready_all = 1'b1;
    ar_min = 0; ar_max = 0; r_min = 0; r_max = 0; ar_lat_cur = 0; r_lat_cur = 0;
    mem_busy = 1'b0; ar_iter = 0; rv_first = 0; rv_seen = 1'b0;
    for (int a = 0; a < 16; a++) begin mem_data[a] = $urandom; mem_resp[a] = 2'b00; end
    clear_logs();
    test_reset();
    test_m0_single();
    test_round_robin();
    test_busy_wait();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
